// File: rtl/logs_iterate_multi.sv
`default_nettype none
// ============================================================================
//  Module   : logs_iterate_multi
//  Purpose  : Multi-channel fixed-point logistic map x <= r*x*(1-x) sharing
//             one serial shift-and-add multiplier, serviced round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module logs_iterate_multi #(
    parameter int FRAC      = 8,
    parameter int R_INT     = 2,
    parameter int CHANNELS  = 4,
    parameter int SATURATE  = 1,
    parameter int INITIAL_X = 1 << (FRAC - 4),
    localparam int RW       = R_INT + FRAC,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [CHANNELS*RW-1:0]   r_all,
    input  logic                     load,
    input  logic [CW-1:0]            load_ch,
    input  logic [FRAC-1:0]          load_x,
    output logic [CHANNELS*FRAC-1:0] x_all,
    output logic                     next_ready,
    output logic [CW-1:0]            next_ch
);

    localparam int ACCW = R_INT + 2*FRAC;
    localparam int KW   = $clog2(2*FRAC + 3);

    localparam logic [KW-1:0]   c_K_MUL2   = KW'(FRAC + 1);
    localparam logic [KW-1:0]   c_K_LAST   = KW'(2*FRAC + 2);
    localparam logic [CW:0]     c_NCH      = (CW+1)'(CHANNELS);
    localparam logic [CW-1:0]   c_CH_LAST  = CW'(CHANNELS - 1);
    localparam logic [FRAC-1:0] c_INIT_X   = FRAC'(INITIAL_X);

    logic [FRAC-1:0] r_x [CHANNELS];
    logic [KW-1:0]   r_k;
    logic [CW-1:0]   r_ch;
    logic [ACCW-1:0] r_a;
    logic [ACCW-1:0] r_acc;
    logic [FRAC-1:0] r_b;
    logic            r_abort;
    logic            r_next_ready;
    logic [CW-1:0]   r_next_ch;

    logic [FRAC-1:0]  w_x_cur;
    logic [RW-1:0]    w_r_cur;
    logic             w_load_ok;
    logic             w_hit;
    logic [FRAC-1:0]  w_p;
    logic [R_INT-1:0] w_int;
    logic [FRAC-1:0]  w_result;

    always_comb begin
        w_x_cur = '0;
        w_r_cur = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_ch == CW'(c)) begin
                w_x_cur = r_x[c];
                w_r_cur = r_all[c*RW +: RW];
            end
        end
    end

    assign w_load_ok = load && ({1'b0, load_ch} < c_NCH);
    assign w_hit     = w_load_ok && (load_ch == r_ch);
    assign w_p       = r_acc[2*FRAC-1:FRAC];
    assign w_int     = r_acc[ACCW-1:2*FRAC];
    assign w_result  = ((SATURATE != 0) && (w_int != '0)) ? '1 : w_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_x[c] <= c_INIT_X;
            end
            r_k          <= '0;
            r_ch         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_abort      <= 1'b0;
            r_next_ready <= 1'b0;
            r_next_ch    <= '0;
        end else begin
            r_next_ready <= 1'b0;
            if (enable) begin
                if (r_k == '0) begin
                    // ~x stands in for 1-x (off by one LSB)
                    r_a   <= ACCW'(w_x_cur);
                    r_b   <= ~w_x_cur;
                    r_acc <= '0;
                    r_k   <= r_k + 1'b1;
                end else if (r_k == c_K_MUL2) begin
                    r_a   <= ACCW'(w_r_cur);
                    r_b   <= w_p;
                    r_acc <= '0;
                    r_k   <= r_k + 1'b1;
                end else if (r_k == c_K_LAST) begin
                    if (!r_abort && !w_hit) begin
                        r_x[r_ch]    <= w_result;
                        r_next_ready <= 1'b1;
                        r_next_ch    <= r_ch;
                    end
                    r_ch <= (r_ch == c_CH_LAST) ? '0 : r_ch + 1'b1;
                    r_k  <= '0;
                end else begin
                    r_acc <= r_acc + (r_b[0] ? r_a : '0);
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_k   <= r_k + 1'b1;
                end
            end

            // A channel counts as in flight once k has left 0, or at k=0 when capture happens now
            if (w_hit && ((r_k != '0) || enable)) begin
                r_abort <= 1'b1;
            end else if (enable && (r_k == '0)) begin
                r_abort <= 1'b0;
            end

            // Placed last so a seed overrides a same-edge writeback
            if (w_load_ok) begin
                r_x[load_ch] <= load_x;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_xout
        assign x_all[c*FRAC +: FRAC] = r_x[c];
    end

    assign next_ready = r_next_ready;
    assign next_ch    = r_next_ch;

endmodule
`default_nettype wire

// File: tb/tb_logs_iterate_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logs_iterate_multi
//  Purpose  : Scoreboard bench for logs_iterate_multi (pulse timing/results).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logs_iterate_multi;

    typedef struct packed {
        int          cyc;
        logic [0:0]  ch;
        logic [15:0] x;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [19:0] r_all;
    logic        ld;
    logic [0:0]  ld_ch;
    logic [7:0]  ld_x;
    logic [15:0] xall;
    logic        nr;
    logic [0:0]  nch;

    logic        en2;
    logic [10:0] r2;
    logic        ld2;
    logic [0:0]  ld2_ch;
    logic [7:0]  ld2_x;
    logic [7:0]  xs1, xs0;
    logic        nrs1, nrs0;
    logic [0:0]  nchs1, nchs0;

    int   cyc = 0;
    int   rel = 0;
    int   checks = 0;
    int   failures = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];

    logs_iterate_multi #(.FRAC(8), .R_INT(2), .CHANNELS(2), .SATURATE(1)) dut (
        .clk(clk), .reset(rst), .enable(en), .r_all(r_all), .load(ld), .load_ch(ld_ch),
        .load_x(ld_x), .x_all(xall), .next_ready(nr), .next_ch(nch));

    logs_iterate_multi #(.FRAC(8), .R_INT(3), .CHANNELS(1), .SATURATE(1)) dut_sat1 (
        .clk(clk), .reset(rst), .enable(en2), .r_all(r2), .load(ld2), .load_ch(ld2_ch),
        .load_x(ld2_x), .x_all(xs1), .next_ready(nrs1), .next_ch(nchs1));

    logs_iterate_multi #(.FRAC(8), .R_INT(3), .CHANNELS(1), .SATURATE(0)) dut_sat0 (
        .clk(clk), .reset(rst), .enable(en2), .r_all(r2), .load(ld2), .load_ch(ld2_ch),
        .load_x(ld2_x), .x_all(xs0), .next_ready(nrs0), .next_ch(nchs0));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (nr === 1'b1) obs_q.push_back(rec_t'{cyc, nch, xall});
    end

    // Reference: r * x * (~x) in 8-bit fraction, truncating each product
    function automatic logic [7:0] f_model(input logic [7:0] x, input int unsigned r, input bit sat);
        int unsigned xi, p, prod;
        xi   = x;
        p    = (xi * (255 - xi)) >> 8;
        prod = r * p;
        if (sat && ((prod >> 16) != 0)) return 8'hFF;
        return 8'(prod >> 8);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rel = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_obs(input int base, input int n, input int budget);
        for (int t = 0; t < budget && obs_q.size() < base + n; t++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; ld = 1'b1; ld_ch = 1'b0; ld_x = 8'h55;
        repeat (3) @(negedge clk);
        checks++;
        if (xall !== 16'h1010) begin failures++; $display("FAIL reset_x: got %h expected 1010", xall); end
        checks++;
        if (nr !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", nr); end
        checks++;
        if (nch !== 1'b0) begin failures++; $display("FAIL reset_ch: got %0d expected 0", nch); end
        rst = 1'b0; ld = 1'b0;
    endtask

    task automatic test_basic();
        int base;
        logic [7:0] x1a, x0b;
        en = 1'b1; r_all = {10'h200, 10'h200};
        do_reset();
        base = obs_q.size();
        x1a = f_model(8'h10, 512, 1'b1);
        x0b = f_model(8'h1C, 512, 1'b1);
        exp_q.push_back(rec_t'{rel + 19, 1'b0, 16'h101C});
        exp_q.push_back(rec_t'{rel + 38, 1'b1, {x1a, 8'h1C}});
        exp_q.push_back(rec_t'{rel + 57, 1'b0, {x1a, x0b}});
        wait_obs(base, 3, 80);
        for (int i = 0; i < 3; i++) begin
            rec_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() <= base + i) begin
                failures++; $display("FAIL basic pulse%0d: missing pulse, expected cyc=%0d ch=%0d x=%h", i, e.cyc, e.ch, e.x);
            end else begin
                o = obs_q[base + i];
                if (o !== e) begin failures++; $display("FAIL basic pulse%0d: got cyc=%0d ch=%0d x=%h expected cyc=%0d ch=%0d x=%h", i, o.cyc, o.ch, o.x, e.cyc, e.ch, e.x); end
            end
        end
    endtask

    task automatic test_load_seq();
        int base;
        en = 1'b1; r_all = {10'h200, 10'h200};
        do_reset();
        base = obs_q.size();
        ld = 1'b1; ld_ch = 1'b1; ld_x = 8'h80;
        @(negedge clk);
        ld = 1'b0;
        exp_q.push_back(rec_t'{rel + 19, 1'b0, 16'h801C});
        exp_q.push_back(rec_t'{rel + 38, 1'b1, 16'h7E1C});
        wait_obs(base, 2, 60);
        for (int i = 0; i < 2; i++) begin
            rec_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() <= base + i) begin
                failures++; $display("FAIL load_seq pulse%0d: missing pulse, expected cyc=%0d ch=%0d x=%h", i, e.cyc, e.ch, e.x);
            end else begin
                o = obs_q[base + i];
                if (o !== e) begin failures++; $display("FAIL load_seq pulse%0d: got cyc=%0d ch=%0d x=%h expected cyc=%0d ch=%0d x=%h", i, o.cyc, o.ch, o.x, e.cyc, e.ch, e.x); end
            end
        end
    endtask

    task automatic test_saturate();
        en = 1'b0; en2 = 1'b0; r2 = 11'h700;
        do_reset();
        ld2 = 1'b1; ld2_ch = 1'b0; ld2_x = 8'h80;
        @(negedge clk);
        ld2_ch = 1'b1; ld2_x = 8'h33;
        @(negedge clk);
        ld2 = 1'b0;
        checks++;
        if (xs1 !== 8'h80 || xs0 !== 8'h80) begin failures++; $display("FAIL sat_seed: got %h/%h expected 80/80", xs1, xs0); end
        en2 = 1'b1;
        for (int t = 0; t < 40 && nrs1 !== 1'b1; t++) @(negedge clk);
        checks++;
        if (cyc !== rel + 21) begin failures++; $display("FAIL sat_timing: got cycle %0d expected %0d", cyc - rel, 21); end
        checks++;
        if (xs1 !== 8'hFF) begin failures++; $display("FAIL sat_clamp: got %h expected ff", xs1); end
        checks++;
        if (xs0 !== 8'hB9 || nrs0 !== 1'b1) begin failures++; $display("FAIL sat_trunc: got %h ready=%b expected b9 ready=1", xs0, nrs0); end
        en2 = 1'b0;
    endtask

    task automatic test_freeze();
        int base;
        en = 1'b1; r_all = {10'h200, 10'h200};
        do_reset();
        base = obs_q.size();
        wait_until(rel + 5);
        en = 1'b0;
        wait_until(rel + 7);
        ld = 1'b1; ld_ch = 1'b1; ld_x = 8'h44;
        @(negedge clk);
        ld = 1'b0;
        checks++;
        if (xall !== 16'h4410) begin failures++; $display("FAIL freeze_load: got %h expected 4410", xall); end
        wait_until(rel + 15);
        checks++;
        if (nr !== 1'b0 || obs_q.size() != base) begin failures++; $display("FAIL freeze_quiet: got ready=%b pulses=%0d expected 0/0", nr, obs_q.size() - base); end
        en = 1'b1;
        exp_q.push_back(rec_t'{rel + 29, 1'b0, 16'h441C});
        exp_q.push_back(rec_t'{rel + 48, 1'b1, {f_model(8'h44, 512, 1'b1), 8'h1C}});
        wait_obs(base, 2, 60);
        for (int i = 0; i < 2; i++) begin
            rec_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() <= base + i) begin
                failures++; $display("FAIL freeze pulse%0d: missing pulse, expected cyc=%0d ch=%0d x=%h", i, e.cyc, e.ch, e.x);
            end else begin
                o = obs_q[base + i];
                if (o !== e) begin failures++; $display("FAIL freeze pulse%0d: got cyc=%0d ch=%0d x=%h expected cyc=%0d ch=%0d x=%h", i, o.cyc, o.ch, o.x, e.cyc, e.ch, e.x); end
            end
        end
    endtask

    task automatic test_abort();
        int base;
        logic [7:0] x0n, x1n;
        en = 1'b1; r_all = {10'h200, 10'h200};
        do_reset();
        base = obs_q.size();
        wait_until(rel + 5);
        ld = 1'b1; ld_ch = 1'b0; ld_x = 8'h5A;
        @(negedge clk);
        ld = 1'b0;
        checks++;
        if (xall !== 16'h105A) begin failures++; $display("FAIL abort_mid_load: got %h expected 105a", xall); end
        wait_until(rel + 37);
        ld = 1'b1; ld_ch = 1'b1; ld_x = 8'h21;
        @(negedge clk);
        ld = 1'b0;
        checks++;
        if (xall !== 16'h215A || nr !== 1'b0) begin failures++; $display("FAIL abort_wb_load: got %h ready=%b expected 215a ready=0", xall, nr); end
        x0n = f_model(8'h5A, 512, 1'b1);
        x1n = f_model(8'h21, 512, 1'b1);
        exp_q.push_back(rec_t'{rel + 57, 1'b0, {8'h21, x0n}});
        exp_q.push_back(rec_t'{rel + 76, 1'b1, {x1n, x0n}});
        wait_obs(base, 2, 60);
        for (int i = 0; i < 2; i++) begin
            rec_t e, o;
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() <= base + i) begin
                failures++; $display("FAIL abort pulse%0d: missing pulse, expected cyc=%0d ch=%0d x=%h", i, e.cyc, e.ch, e.x);
            end else begin
                o = obs_q[base + i];
                if (o !== e) begin failures++; $display("FAIL abort pulse%0d: got cyc=%0d ch=%0d x=%h expected cyc=%0d ch=%0d x=%h", i, o.cyc, o.ch, o.x, e.cyc, e.ch, e.x); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        rec_t e, o;
        en = 1'b1; r_all = {10'h200, 10'h200};
        do_reset();
        base = obs_q.size();
        wait_until(rel + 12);
        rst = 1'b1; ld = 1'b1; ld_ch = 1'b1; ld_x = 8'h77;
        repeat (2) @(negedge clk);
        checks++;
        if (xall !== 16'h1010 || nr !== 1'b0 || obs_q.size() != base) begin
            failures++; $display("FAIL reset_mid_state: got x=%h ready=%b pulses=%0d expected 1010/0/0", xall, nr, obs_q.size() - base);
        end
        rst = 1'b0; ld = 1'b0;
        rel = cyc;
        base = obs_q.size();
        exp_q.push_back(rec_t'{rel + 19, 1'b0, 16'h101C});
        wait_obs(base, 1, 40);
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() <= base) begin
            failures++; $display("FAIL reset_mid pulse: missing pulse, expected cyc=%0d ch=%0d x=%h", e.cyc, e.ch, e.x);
        end else begin
            o = obs_q[base];
            if (o !== e) begin failures++; $display("FAIL reset_mid pulse: got cyc=%0d ch=%0d x=%h expected cyc=%0d ch=%0d x=%h", o.cyc, o.ch, o.x, e.cyc, e.ch, e.x); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; r_all = '0; ld = 1'b0; ld_ch = '0; ld_x = '0;
        en2 = 1'b0; r2 = '0; ld2 = 1'b0; ld2_ch = '0; ld2_x = '0;
        test_reset();
        test_basic();
        test_load_seq();
        test_saturate();
        test_freeze();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logs_iterate_multi.md
LOGS_ITERATE_MULTI -- requirements
Module: logs_iterate_multi

Interface
REQ-001 SHALL have parameter FRAC, default 8: fraction bits of x and r (FRAC >= 4).
REQ-002 SHALL have parameter R_INT, default 2: integer bits of r, giving RW = R_INT+FRAC.
REQ-003 SHALL have parameter CHANNELS, default 4: independent logistic-map channels (>= 1).
REQ-004 SHALL have parameter SATURATE, default 1: 1 = clamp overflowing results, 0 = truncate.
REQ-005 SHALL have parameter INITIAL_X, default 1<<(FRAC-4): reset value of every channel's x.
REQ-006 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-008 SHALL have port enable  input  1  1 = iterate; 0 = freeze the iteration sequencer.
REQ-009 SHALL have port r_all  input  CHANNELS*RW  per-channel r, unsigned R_INT.FRAC; channel c at [c*RW +: RW].
REQ-010 SHALL have port load  input  1  seed strobe.
REQ-011 SHALL have port load_ch  input  clog2(CHANNELS) (min 1)  channel to seed.
REQ-012 SHALL have port load_x  input  FRAC  seed value, 0.FRAC.
REQ-013 SHALL have port x_all  output  CHANNELS*FRAC  registered x per channel; channel c at [c*FRAC +: FRAC].
REQ-014 SHALL have port next_ready  output  1  one-cycle pulse: a channel's x was updated by an iteration.
REQ-015 SHALL have port next_ch  output  clog2(CHANNELS) (min 1)  channel updated; valid while next_ready=1.

Function
REQ-016 SHALL share one shift-and-add multiplier across all channels, serviced round-robin 0,1,...,CHANNELS-1,0,...
REQ-017 SHALL process each channel in one iteration of CYCLE_LEN = 2*FRAC+3 enabled cycles, phase counter k = 0..2*FRAC+2.
REQ-018 At k=0 SHALL capture the current channel's x as multiplicand A, ~x (approximating 1-x) as multiplier B, and clear the accumulator.
REQ-019 At k=1..FRAC SHALL add A to the accumulator when B[0]=1, then shift A left by 1 and B right by 1.
REQ-020 At k=FRAC+1 SHALL form p = product bits [2*FRAC-1:FRAC], load A = r of the current channel (sampled from r_all at this cycle), load B = p, and clear the accumulator.
REQ-021 At k=FRAC+2..2*FRAC+1 SHALL repeat the REQ-019 step.
REQ-022 The accumulator SHALL be at least R_INT+2*FRAC bits wide, with no overflow.
REQ-023 At k=2*FRAC+2, result fraction SHALL be product bits [2*FRAC-1:FRAC]; integer bits [R_INT+2*FRAC-1:2*FRAC] nonzero with SATURATE=1 SHALL yield all-ones; with SATURATE=0 SHALL yield the fraction bits unchanged.
REQ-024 At k=2*FRAC+2 SHALL write the result to that channel's x, pulse next_ready for one cycle with next_ch = channel, then advance the channel (CHANNELS-1 wraps to 0) and set k = 0.
REQ-025 When enable=0, k, channel pointer, A, B and accumulator SHALL hold; next_ready SHALL be 0; load SHALL still apply.
REQ-026 load=1 with load_ch < CHANNELS SHALL write load_x to x[load_ch] at that edge; load_ch >= CHANNELS SHALL be ignored.
REQ-027 A load to the channel currently in flight (k >= 1) SHALL abort that iteration: the k=2*FRAC+2 writeback and next_ready pulse are suppressed, while the sequence timing and channel advance are unchanged.
REQ-028 A load coinciding with writeback to the same channel SHALL win: load_x is stored and there is no next_ready.
REQ-029 A load at k=0 to the current channel SHALL store load_x; the iteration proceeds on the pre-load x captured that cycle and is also aborted.

Reset
REQ-030 On reset=1 at an edge: all x = INITIAL_X, next_ready = 0, next_ch = 0, k = 0, channel pointer = 0, accumulator = 0; loads are ignored.
REQ-031 Reset asserted mid-iteration SHALL discard the in-flight computation with no next_ready pulse.

Verification
REQ-032 Reset with FRAC=8, R_INT=2, CHANNELS=2, enable=1, r0 = 0x200 (2.0) -> after the 19th edge following reset release, next_ready=1, next_ch=0, x0 = 0x1C; x1 = 0x10 is unchanged.
REQ-033 Load ch1 = 0x80, r1 = 0x200 -> the ch1 iteration gives p = 0x3F and x1 = 0x7E, with next_ch=1 exactly 19 cycles after ch0's pulse.
REQ-034 R_INT=3, x = 0x80, r = 0x700 (7.0) -> SATURATE=1 gives 0xFF; SATURATE=0 gives 0xB9.
REQ-035 Hold enable=0 for 10 cycles mid-iteration -> the next_ready pulse is delayed exactly 10 cycles with an identical result; a load during the freeze updates x_all at once.
REQ-036 Load the in-flight channel at k=5, and separately at k=2*FRAC+2 -> in both cases x = load_x with no next_ready, and the next channel then starts on schedule.
REQ-037 Assert reset at k=12 -> all x = 0x10 and no pulse; the next pulse arrives 19 edges after reset release, for channel 0.
